// File: rtl/debouncer_pkg.sv
// Shared definitions for the level debouncer.
//
// Contents:
//   act_e      - per-edge action taken by the debouncer
//   tol_period - tolerance period T (in clocks) for a given counter width
package debouncer_pkg;

  // What one rising edge does to the state.
  typedef enum logic [1:0] {
    ActHold,   // input agrees with output: clear any pending change
    ActCount,  // input disagrees, threshold not yet reached
    ActFlip    // input disagreed for the T-th consecutive sample
  } act_e;

  // Tolerance period T = 2^width clocks.
  function automatic int unsigned tol_period(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Level debouncer: o_output follows i_input only after i_input has disagreed with it for
// 2^p_CNT_WIDTH consecutive rising edges. Any agreeing sample aborts a pending change.
// No synchronizer inside: i_input must already be synchronous to i_clk.
//
// Parameters:
//   p_CNT_WIDTH  - stability counter width (>= 1); tolerance T = 2^p_CNT_WIDTH clocks
//   p_INIT_VALUE - output value after reset
//
// Ports:
//   i_clk    - clock, all state updates on the rising edge
//   i_rst    - asynchronous active-high reset
//   i_input  - raw level to debounce
//   o_output - debounced level, driven straight from a register
module debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned p_CNT_WIDTH  = 2,
  parameter logic        p_INIT_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_input,
  output logic o_output
);

  localparam int unsigned T = tol_period(p_CNT_WIDTH);

  // Terminal count T-1 is all ones, so the counter can never wrap.
  localparam logic [p_CNT_WIDTH-1:0] TermCnt = p_CNT_WIDTH'(T - 1);

  logic                   out_q, out_d;
  logic [p_CNT_WIDTH-1:0] cnt_q, cnt_d;
  act_e                   act;

  // Classify this edge.
  always_comb begin
    act = ActHold;
    if (i_input != out_q) begin
      act = (cnt_q == TermCnt) ? ActFlip : ActCount;
    end
  end

  // Next-state.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    unique case (act)
      ActHold:  cnt_d = '0;
      ActCount: cnt_d = cnt_q + 1'b1;
      ActFlip: begin
        out_d = i_input;
        cnt_d = '0;
      end
      default:  cnt_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q <= p_INIT_VALUE;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_output = out_q;

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (W=2, T=4, init 0). Inputs change on falling edges,
// output is sampled 1 time unit after each rising edge. The reference model keeps the last
// T samples and flips its output when all of them disagree with it.
module tb_debouncer;

  localparam int unsigned CntWidth  = 2;
  localparam int unsigned T         = 1 << CntWidth;
  localparam logic        InitValue = 1'b0;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic model_out;
  logic hist[$];

  debouncer #(
    .p_CNT_WIDTH (CntWidth),
    .p_INIT_VALUE(InitValue)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_input (din),
    .o_output(dout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_out = InitValue;
    hist.delete();
  endtask

  // Output takes the new level once the last T samples all disagree with it.
  task automatic model_sample(input logic s);
    bit all_diff;
    hist.push_back(s);
    if (hist.size() > T) void'(hist.pop_front());
    all_diff = (hist.size() == T);
    foreach (hist[i]) if (hist[i] == model_out) all_diff = 1'b0;
    if (all_diff) model_out = s;
  endtask

  // Called at a falling edge: drive, take one rising edge, check, return at next falling edge.
  task automatic step(input logic v, input string tag);
    din = v;
    @(posedge clk);
    if (!rst) model_sample(v);
    #1 check_eq(tag, dout, model_out);
    @(negedge clk);
  endtask

  task automatic hold(input logic v, input int unsigned n, input string tag);
    for (int i = 0; i < n; i++) step(v, tag);
  endtask

  initial begin
    logic lvl;
    int unsigned len;

    // Reset with input high: output held at init throughout.
    rst = 1'b1;
    din = 1'b1;
    model_reset();
    #1 check_eq("rst_imm", dout, InitValue);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_eq("rst_hold", dout, InitValue);
    end
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 3, "post_rst_wait");
    step(1'b1, "post_rst_flip");
    check_eq("post_rst_one", dout, 1'b1);
    hold(1'b0, T, "back_to_zero");

    // Toggle every clock: no change.
    for (int i = 0; i < 12; i++) step(1'(i % 2 == 0), "toggle");
    check_eq("toggle_end", dout, 1'b0);

    // Hold each level T-1 clocks: no change.
    for (int i = 0; i < 12; i++) hold(1'(i % 2 == 0), T - 1, "hold3");
    check_eq("hold3_end", dout, 1'b0);

    // Hold each level exactly T clocks: flips on the T-th edge every time.
    lvl = 1'b1;
    for (int i = 0; i < 12; i++) begin
      hold(lvl, T - 1, "hold4_pre");
      check_eq("hold4_old", dout, ~lvl);
      step(lvl, "hold4_edge");
      check_eq("hold4_new", dout, lvl);
      lvl = ~lvl;
    end

    // Pending 1->0 change aborted by reset after 2 edges.
    hold(1'b1, T, "pre_abort");
    hold(1'b0, 2, "abort_cnt");
    check_eq("abort_still1", dout, 1'b1);
    rst = 1'b1;
    model_reset();
    #1 check_eq("abort_rst", dout, 1'b0);
    @(posedge clk);
    #1 check_eq("abort_rst_hold", dout, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Interrupted run restarts the count.
    hold(1'b1, 2, "restart_a");
    step(1'b0, "restart_b");
    hold(1'b1, 3, "restart_c");
    check_eq("restart_not_yet", dout, 1'b0);
    step(1'b1, "restart_d");
    check_eq("restart_flip", dout, 1'b1);

    // Random runs with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 19) == 0) begin
        #($urandom_range(1, 3));
        rst = 1'b1;
        model_reset();
        #1 check_eq("rand_rst", dout, InitValue);
        @(posedge clk);
        #1 check_eq("rand_rst_hold", dout, InitValue);
        @(negedge clk);
        rst = 1'b0;
      end
      hold(lvl, len, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Filters a noisy single-bit level (button or switch) into a clean level.
- The output changes only after the input has disagreed with it for 2^p_CNT_WIDTH consecutive clock samples.
- Sits between board-level inputs and control logic.
- Contains no synchronizer: the input must already be synchronous to i_clk, or be synchronized upstream.

Parameters:
- p_CNT_WIDTH, default 2: width of the stability counter. Tolerance period T = 2^p_CNT_WIDTH clocks. Legal range >= 1.
- p_INIT_VALUE, default 1'b0: output value after reset and at power-up.

Ports:
- i_clk   input  1  clock; all state updates on the rising edge.
- i_rst   input  1  asynchronous, active-high reset.
- i_input  input  1  raw level to debounce; synchronous to i_clk.
- o_output output 1  debounced level, driven directly from a register.

Behaviour:
- State:
  - r_out: 1-bit output register; o_output = r_out.
  - r_cnt: p_CNT_WIDTH-bit counter.
- Reset (i_rst high, asynchronous, takes effect immediately): r_out = p_INIT_VALUE, r_cnt = 0. Both are held while i_rst is high.
- Initial values (for simulation without reset): r_out = p_INIT_VALUE, r_cnt = 0.
- Each rising i_clk edge with i_rst low:
  - If i_input == r_out: r_cnt <= 0, r_out unchanged. Any agreeing sample aborts a pending change.
  - If i_input != r_out and r_cnt != T-1: r_cnt <= r_cnt + 1, r_out unchanged.
  - If i_input != r_out and r_cnt == T-1: r_out <= i_input, r_cnt <= 0.
- Latency:
  - The output flips on exactly the T-th consecutive rising edge that samples the differing input.
  - Example (W=2): input changes between edges; edges 1–3 give no change; edge 4 gives o_output = new value.
- Sub-threshold noise:
  - An input that differs for only 1..T-1 consecutive samples never changes o_output.
  - This includes toggling every clock, or holding each level for T-1 clocks.
- Counter arithmetic:
  - r_cnt never wraps; it returns to 0 on an output change or on agreement.
  - No saturation logic is needed because T-1 is the terminal count.
- Reset asserted mid-count: the count is discarded and the output returns to p_INIT_VALUE immediately.
- After reset deasserts, counting restarts from 0 against p_INIT_VALUE.
- Output is glitch-free: it changes only on a clock edge or on reset assertion.

Decomposition:
- No shared package is required.
- T may be a localparam computed as 1 << p_CNT_WIDTH.
- Single flat module; no sub-module is natural.

Test Plan (W=2, T=4, p_INIT_VALUE=0, input driven on falling edges):
1. Reset: assert i_rst with i_input=1 for 3 clocks, then deassert -> o_output=0 throughout the reset and afterwards until 4 stable samples are taken.
2. Toggle i_input every clock for 12 clocks -> o_output stays 0. A monitor flags any change of o_output.
3. Hold each level for 3 clocks, alternating 12 times -> o_output never changes.
4. Hold each level for exactly 4 clocks, alternating 12 times:
   - o_output stays at its old value through edges 1–3.
   - o_output equals i_input at the falling edge following edge 4, every time.
5. Start a 1->0 change request, and assert i_rst after 2 sampled edges -> o_output=0 immediately.
6. Set i_input=1, let 2 edges pass, then set i_input=0 for 1 edge, then i_input=1 again -> counting restarts from 0. o_output rises only on the 4th consecutive edge sampling 1.
